// File: rtl/timer_irq_ctrl_pkg.sv
// rtl/timer_irq_ctrl_pkg.sv - shared constants, types and helpers for timer_irq_ctrl
// Purpose: register word addresses, bus FSM state enum, register select struct,
//          reset values, OVR/COAL widths, and small saturating-arithmetic helpers.
// Ports:   none (package).
package timer_irq_pkg;

    localparam int ADDR_PEND  = 0;
    localparam int ADDR_MASK  = 1;
    localparam int ADDR_FORCE = 2;
    localparam int ADDR_OVR   = 3;
    localparam int ADDR_COAL  = 4;

    localparam int OVR_W  = 8;
    localparam int COAL_W = 8;

    localparam logic [OVR_W-1:0]  OVR_RST  = 8'd0;
    localparam logic [COAL_W-1:0] COAL_RST = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

    typedef struct packed {
        logic pend;
        logic mask;
        logic frc;
        logic ovr;
        logic coal;
    } reg_sel_t;

    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // 8-bit add that sticks at 8'hFF instead of wrapping
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b00000, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// rtl/timer_irq_ctrl_if.sv - req/gnt register bus interface for timer_irq_ctrl
// Purpose: bundles the software register bus shared with the timer block.
// Ports:   req_i/wr_i/addr_i/wdata_i (master -> slave),
//          gnt_o/rvalid_o/rdata_o/err_o (slave -> master).
interface timer_irq_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              req_i;
    logic              wr_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              gnt_o;
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;

    modport master (
        output req_i, wr_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, wr_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/timer_irq_ctrl_bus_if.sv
// rtl/timer_irq_ctrl_bus_if.sv - req/gnt/rvalid bus FSM and address decode
// Purpose: IDLE -> ACCESS (gnt_o) -> RESP (rvalid_o) sequencer; emits one-cycle
//          wr_stb/rd_stb during ACCESS plus per-register selects; registers the
//          read data / error into the response.
// Ports:   clk, rst (async active-high), bus (slave modport), rd_data (register
//          mux from the top), wr_stb, rd_stb, sel.
// Config:  IRQ_COALESCE_EN maps the COAL register at word address 0x4.
module timer_irq_bus_if
    import timer_irq_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    timer_irq_ctrl_if.slave     bus,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                wr_stb,
    output logic                rd_stb,
    output reg_sel_t            sel
);

    bus_state_e state;
    logic       mapped;

    // addr_i is held by the master through the ACCESS cycle, so decode it live
    always_comb begin
        sel      = '0;
        sel.pend = (bus.addr_i == ADDR_W'(ADDR_PEND));
        sel.mask = (bus.addr_i == ADDR_W'(ADDR_MASK));
        sel.frc  = (bus.addr_i == ADDR_W'(ADDR_FORCE));
        sel.ovr  = (bus.addr_i == ADDR_W'(ADDR_OVR));
`ifdef IRQ_COALESCE_EN
        sel.coal = (bus.addr_i == ADDR_W'(ADDR_COAL));
`endif
    end

    assign mapped = |sel;
    assign wr_stb = (state == ST_ACCESS) &&  bus.wr_i;
    assign rd_stb = (state == ST_ACCESS) && !bus.wr_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bus.gnt_o    <= 1'b0;
            bus.rvalid_o <= 1'b0;
            bus.rdata_o  <= '0;
            bus.err_o    <= 1'b0;
        end else begin
            bus.gnt_o    <= 1'b0;
            bus.rvalid_o <= 1'b0;
            bus.rdata_o  <= '0;
            bus.err_o    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_i) begin
                        state     <= ST_ACCESS;
                        bus.gnt_o <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    // capture pre-update register contents (clear-on-read sees old OVR)
                    state        <= ST_RESP;
                    bus.rvalid_o <= 1'b1;
                    bus.err_o    <= !mapped;
                    bus.rdata_o  <= (!bus.wr_i && mapped) ? rd_data : '0;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - timer interrupt controller: pending/mask/force/overrun, level IRQ
// Purpose: latches timer expiry pulses into PEND, counts overruns in OVR (clear on
//          read, saturating), masks with MASK and drives a registered level irq_o.
// Ports:   clk, rst (async active-high), evt_i[N_SRC] expiry pulses,
//          bus (slave modport of timer_irq_ctrl_if), irq_o level interrupt.
// Config:  IRQ_COALESCE_EN adds COAL (0x4) and an event counter gating irq_o.
module timer_irq_ctrl
    import timer_irq_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   evt_i,
    timer_irq_ctrl_if.slave    bus,
    output logic               irq_o
);

    logic [N_SRC-1:0] pend_q, mask_q, pend_next, mask_next;
    logic [N_SRC-1:0] w1c, fset, ovr_hits, wdata_src;
    logic [OVR_W-1:0] ovr_q, ovr_next;
    logic [7:0]       hits8;
    logic [DATA_W-1:0] rd_data;
    logic             wr_stb, rd_stb, irq_next;
    reg_sel_t         sel;
    logic             unused_wdata;

    timer_irq_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bus (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .rd_data (rd_data),
        .wr_stb  (wr_stb),
        .rd_stb  (rd_stb),
        .sel     (sel)
    );

    assign wdata_src    = bus.wdata_i[N_SRC-1:0];
    assign unused_wdata = &{1'b0, bus.wdata_i};

    always_comb begin
        w1c       = (wr_stb && sel.pend) ? wdata_src : '0;
        fset      = (wr_stb && sel.frc)  ? wdata_src : '0;
        // event set wins over a same-edge W1C
        pend_next = (pend_q & ~w1c) | fset | evt_i;
        mask_next = (wr_stb && sel.mask) ? wdata_src : mask_q;
        // a bit being cleared and re-set at the same edge is not an overrun
        ovr_hits  = evt_i & pend_q & ~w1c;
        hits8     = '0;
        hits8[N_SRC-1:0] = ovr_hits;
        ovr_next  = sat_add8((rd_stb && sel.ovr) ? OVR_RST : ovr_q, count_ones(hits8));
    end

`ifdef IRQ_COALESCE_EN
    logic [COAL_W-1:0] coal_q, coal_next, coal_eff, cnt_q, cnt_next;
    logic [7:0]        evt8;

    always_comb begin
        coal_next = (wr_stb && sel.coal) ? bus.wdata_i[COAL_W-1:0] : coal_q;
        coal_eff  = (coal_next == '0) ? 8'd1 : coal_next;
        evt8      = '0;
        evt8[N_SRC-1:0] = evt_i & mask_next;
        cnt_next  = (pend_next == '0) ? '0 : sat_add8(cnt_q, count_ones(evt8));
        irq_next  = (|(pend_next & mask_next)) && (cnt_next >= coal_eff);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coal_q <= COAL_RST;
            cnt_q  <= '0;
        end else begin
            coal_q <= coal_next;
            cnt_q  <= cnt_next;
        end
    end
`else
    logic unused_coal_sel;
    assign unused_coal_sel = sel.coal;
    assign irq_next        = |(pend_next & mask_next);
`endif

    always_comb begin
        rd_data = '0;
        if (sel.pend) rd_data[N_SRC-1:0] = pend_q;
        if (sel.mask) rd_data[N_SRC-1:0] = mask_q;
        if (sel.ovr)  rd_data[OVR_W-1:0] = ovr_q;
`ifdef IRQ_COALESCE_EN
        if (sel.coal) rd_data[COAL_W-1:0] = coal_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            mask_q <= '0;
            ovr_q  <= OVR_RST;
            irq_o  <= 1'b0;
        end else begin
            pend_q <= pend_next;
            mask_q <= mask_next;
            ovr_q  <= ovr_next;
            irq_o  <= irq_next;
        end
    end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - scoreboard testbench for timer_irq_ctrl
module tb_timer_irq_ctrl;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] evt_i = '0;
    logic         irq_o;

    timer_irq_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    timer_irq_ctrl #(.N_SRC(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .evt_i (evt_i),
        .bus   (bus.slave),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          err;
    } resp_t;

    resp_t sbq[$];
    int    total = 0;
    int    bad   = 0;
    bit    mon_en = 1'b0;
    bit    rnd_on = 1'b0;

    bit    m_pend[N];
    bit    m_mask[N];
    int    m_ovr, m_cnt, m_coal;
    bit    exp_irq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_pend[k] = 1'b0;
            m_mask[k] = 1'b0;
        end
        m_ovr   = 0;
        m_cnt   = 0;
        m_coal  = 1;
        exp_irq = 1'b0;
    endfunction

    // Reference behaviour for one clock edge; pushes the expected response on a commit edge
    function automatic void model_step(input logic [N-1:0] ev, input bit commit, input bit wr,
                                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
        resp_t r;
        int    ai, add, hits, thr;
        bit    mapped, clr, frc, any_irq, any_pend;
        ai     = int'(a);
        mapped = (ai <= 3);
`ifdef IRQ_COALESCE_EN
        mapped = mapped || (ai == 4);
`endif
        if (commit) begin
            r.data = 0;
            r.err  = !mapped;
            if (!wr && mapped) begin
                case (ai)
                    0: for (int k = 0; k < N; k++) r.data += 32'(m_pend[k]) << k;
                    1: for (int k = 0; k < N; k++) r.data += 32'(m_mask[k]) << k;
                    3: r.data = 32'(m_ovr);
                    4: r.data = 32'(m_coal);
                    default: r.data = 0;
                endcase
            end
            sbq.push_back(r);
        end
        add = 0;
        for (int k = 0; k < N; k++) begin
            clr = commit && wr && ai == 0 && wd[k];
            frc = commit && wr && ai == 2 && wd[k];
            if (ev[k] && m_pend[k] && !clr) add++;
            m_pend[k] = ev[k] || frc || (m_pend[k] && !clr);
            if (commit && wr && ai == 1) m_mask[k] = wd[k];
        end
        if (commit && !wr && ai == 3) m_ovr = 0;
        m_ovr = (m_ovr + add > 255) ? 255 : m_ovr + add;
        if (commit && wr && ai == 4 && mapped) m_coal = int'(wd[7:0]);
        hits = 0; any_pend = 0; any_irq = 0;
        for (int k = 0; k < N; k++) begin
            if (ev[k] && m_mask[k]) hits++;
            if (m_pend[k]) any_pend = 1;
            if (m_pend[k] && m_mask[k]) any_irq = 1;
        end
        m_cnt = !any_pend ? 0 : ((m_cnt + hits > 255) ? 255 : m_cnt + hits);
`ifdef IRQ_COALESCE_EN
        thr     = (m_coal == 0) ? 1 : m_coal;
        exp_irq = any_irq && (m_cnt >= thr);
`else
        thr     = 0;
        exp_irq = any_irq && (m_cnt >= thr);
`endif
    endfunction

    function automatic logic [N-1:0] nev(input logic [N-1:0] e);
        logic [N-1:0] rv;
        rv = N'($urandom);
        if (rnd_on && $urandom_range(0, 3) == 0) return e | rv;
        return e;
    endfunction

    task automatic idle(input int n, input logic [N-1:0] e);
        repeat (n) begin
            @(negedge clk);
            evt_i = nev(e);
            @(posedge clk);
            model_step(evt_i, 1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic txn(input bit wr, input int a, input logic [DW-1:0] wd, input logic [N-1:0] ec);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_i = 1'b1; bus.wr_i = wr; bus.addr_i = AW'(a); bus.wdata_i = wd;
        evt_i = nev('0);
        @(posedge clk);
        model_step(evt_i, 1'b0, wr, AW'(a), wd);
        @(negedge clk);
        while (!bus.gnt_o && n < 4) begin
            evt_i = nev('0);
            @(posedge clk);
            model_step(evt_i, 1'b0, wr, AW'(a), wd);
            @(negedge clk);
            n++;
        end
        chk("gnt_latency", n, 0);
        bus.req_i = 1'b0;
        if (!bus.gnt_o) return;
        evt_i = nev(ec);
        @(posedge clk);
        model_step(evt_i, 1'b1, wr, AW'(a), wd);
        @(negedge clk);
        chk("rvalid_latency", bus.rvalid_o, 1);
        evt_i = nev('0);
        @(posedge clk);
        model_step(evt_i, 1'b0, wr, AW'(a), wd);
    endtask

    // Monitor: irq level every cycle, responses popped from the scoreboard
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                chk("irq_level", irq_o, exp_irq);
                if (bus.rvalid_o) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_rvalid", 1, 0);
                    end else begin
                        r = sbq.pop_front();
                        chk("rdata", bus.rdata_o, r.data);
                        chk("err", bus.err_o, r.err);
                    end
                end else begin
                    chk("rdata_idle_zero", bus.rdata_o, 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_i = 1'b0; bus.wr_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_gnt", bus.gnt_o, 0);
        chk("rst_rvalid", bus.rvalid_o, 0);
        chk("rst_irq", irq_o, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // reset in the middle of an ACCESS cycle aborts the MASK write
        @(negedge clk);
        bus.req_i = 1'b1; bus.wr_i = 1'b1; bus.addr_i = 4'h1; bus.wdata_i = 32'hF;
        @(posedge clk);
        model_step(evt_i, 1'b0, 1'b1, 4'h1, 32'hF);
        @(negedge clk);
        chk("t1_gnt", bus.gnt_o, 1);
        rst = 1'b1;
        #1;
        chk("t1_gnt_rst", bus.gnt_o, 0);
        chk("t1_rvalid_rst", bus.rvalid_o, 0);
        chk("t1_irq_rst", irq_o, 0);
        model_reset();
        bus.req_i = 1'b0;
        @(negedge clk);
        chk("t1_rvalid_after", bus.rvalid_o, 0);
        rst = 1'b0;
        txn(0, 0, 0, '0);
        txn(0, 1, 0, '0);
        txn(0, 3, 0, '0);

        // mask, event, read PEND, W1C drops irq
        txn(1, 1, 32'h1, '0);
        idle(1, 4'h1);
        idle(1, '0);
        txn(0, 0, 0, '0);
        txn(1, 0, 32'h1, '0);

        // overrun counting, clear-on-read, saturation, event during OVR read
        txn(1, 1, 32'h0, '0);
        txn(1, 2, 32'h4, '0);
        repeat (3) begin
            idle(1, 4'h4);
            idle(1, '0);
        end
        txn(0, 3, 0, '0);
        txn(0, 3, 0, '0);
        idle(300, 4'h4);
        txn(0, 3, 0, '0);
        txn(0, 3, 0, 4'h4);
        txn(0, 3, 0, '0);

        // W1C collides with a new event on the same bit
        txn(1, 0, 32'hF, '0);
        txn(1, 1, 32'h1, '0);
        idle(1, 4'h1);
        txn(1, 0, 32'h1, 4'h1);
        txn(0, 0, 0, '0);
        txn(0, 3, 0, '0);

        // unmapped access, FORCE with partial mask
        txn(0, 7, 0, '0);
        txn(1, 5, 32'h3, '0);
        txn(1, 0, 32'hF, '0);
        txn(1, 1, 32'h8, '0);
        txn(1, 2, 32'hA, '0);
        txn(0, 0, 0, '0);
        txn(0, 2, 0, '0);
        txn(0, 4, 0, '0);

`ifdef IRQ_COALESCE_EN
        txn(1, 0, 32'hF, '0);
        txn(1, 4, 32'h3, '0);
        txn(1, 1, 32'h1, '0);
        repeat (3) begin
            idle(1, 4'h1);
            idle(2, '0);
        end
        txn(1, 0, 32'h1, '0);
        idle(1, 4'h1);
        idle(1, '0);
        txn(1, 4, 32'h0, '0);
        idle(1, 4'h1);
        txn(0, 4, 0, '0);
`endif

        // randomized traffic
        rnd_on = 1'b1;
        repeat (250) begin
            txn(1'($urandom), int'($urandom_range(0, 7)), $urandom, N'($urandom));
            idle(int'($urandom_range(0, 3)), '0);
        end
        rnd_on = 1'b0;
        idle(4, '0);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
